// File: rtl/lock_pkg.sv
// Shared types and encodings for the PIN lock sequencer.
package lock_pkg;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_UNLOCKED,
    S_ADJ_NEW,
    S_ADJ_CONFIRM,
    S_LOCKOUT
  } state_t;

  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_UNLOCKED = 2'd1;
  localparam logic [1:0] ST_ADJUST   = 2'd2;
  localparam logic [1:0] ST_LOCKOUT  = 2'd3;

  localparam logic [15:0] DEFAULT_PIN = 16'h4321;

endpackage

// File: rtl/beep_timer.sv
// Tone-generator control: play held for BEEP_CYCLES after each start,
// a start while playing retriggers and updates the tone type.
module beep_timer #(
  parameter int BEEP_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ok,
  output logic play,
  output logic ok_not_fail
);

  localparam int            BW        = $clog2(BEEP_CYCLES) + 1;
  localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_CYCLES);

  logic [BW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      play        <= 1'b0;
      ok_not_fail <= 1'b0;
    end else if (start) begin
      cnt         <= BEEP_LOAD;
      play        <= 1'b1;
      ok_not_fail <= ok;
    end else if (play) begin
      // terminal count of 1 ends the tone exactly BEEP_CYCLES edges after start
      if (cnt <= BW'(1)) begin
        cnt  <= '0;
        play <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// PIN entry lock with failed-attempt lockout, PIN change with confirmation
// and a beep on every success/fail event.
//
// state         | meaning
// S_LOCKED      | waiting for a correct PIN
// S_UNLOCKED    | open; btn_lock edge relocks, sw[1] enters adjust
// S_ADJ_NEW     | waiting for the new PIN candidate
// S_ADJ_CONFIRM | waiting for the candidate to be re-entered
// S_LOCKOUT     | too many wrong PINs; entries ignored until timer expires
module lock_sequencer #(
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 500_000_000,
  parameter int          BEEP_CYCLES    = 10_000_000,
  parameter logic [15:0] DEFAULT_PIN    = lock_pkg::DEFAULT_PIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pin_valid,
  input  logic [15:0] user_pin,
  input  logic        btn_lock,
  input  logic [1:0]  sw,
  output logic [1:0]  status,
  output logic [15:0] stored_pin,
  output logic        success_event,
  output logic        fail_event,
  output logic        play,
  output logic        ok_not_fail,
  output logic [1:0]  fail_count
);

  import lock_pkg::*;

  localparam int            LW        = $clog2(LOCKOUT_CYCLES) + 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  state_t        state, state_nxt;
  logic          btn_q;
  logic [15:0]   cand;
  logic [LW-1:0] lock_cnt;
  logic          succ_nxt, fail_nxt, cand_ld, pin_wr, fc_clr, fc_inc;
  logic          btn_rise, lock_done, fail_limit;
  logic [1:0]    fail_inc;
  logic          unused_sw;

  assign unused_sw  = sw[0];
  assign btn_rise   = btn_lock & ~btn_q;
  assign lock_done  = (lock_cnt <= LW'(1));
  assign fail_inc   = (fail_count == 2'd3) ? 2'd3 : fail_count + 2'd1;
  assign fail_limit = (int'(fail_inc) >= MAX_FAILS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_LOCKED;
      btn_q         <= 1'b0;
      stored_pin    <= DEFAULT_PIN;
      cand          <= '0;
      fail_count    <= '0;
      lock_cnt      <= '0;
      success_event <= 1'b0;
      fail_event    <= 1'b0;
    end else begin
      state         <= state_nxt;
      btn_q         <= btn_lock;
      success_event <= succ_nxt;
      fail_event    <= fail_nxt;
      if (cand_ld) cand <= user_pin;
      if (pin_wr) stored_pin <= cand;
      if (fc_clr) fail_count <= '0;
      else if (fc_inc) fail_count <= fail_inc;
      if (state_nxt == S_LOCKOUT && state != S_LOCKOUT) lock_cnt <= LOCK_LOAD;
      else if (state == S_LOCKOUT && lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    succ_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    cand_ld   = 1'b0;
    pin_wr    = 1'b0;
    fc_clr    = 1'b0;
    fc_inc    = 1'b0;
    unique case (state)
      S_LOCKED: begin
        if (pin_valid) begin
          if (user_pin == stored_pin) begin
            state_nxt = S_UNLOCKED;
            succ_nxt  = 1'b1;
            fc_clr    = 1'b1;
          end else begin
            fail_nxt = 1'b1;
            fc_inc   = 1'b1;
            if (fail_limit) state_nxt = S_LOCKOUT;
          end
        end
      end
      S_UNLOCKED: begin
        if (btn_rise)   state_nxt = S_LOCKED;
        else if (sw[1]) state_nxt = S_ADJ_NEW;
      end
      S_ADJ_NEW: begin
        if (btn_rise)    state_nxt = S_LOCKED;
        else if (!sw[1]) state_nxt = S_UNLOCKED;
        else if (pin_valid) begin
          cand_ld   = 1'b1;
          state_nxt = S_ADJ_CONFIRM;
        end
      end
      S_ADJ_CONFIRM: begin
        if (btn_rise)    state_nxt = S_LOCKED;
        else if (!sw[1]) state_nxt = S_UNLOCKED;
        else if (pin_valid) begin
          state_nxt = S_UNLOCKED;
          if (user_pin == cand) begin
            pin_wr   = 1'b1;
            succ_nxt = 1'b1;
          end else begin
            fail_nxt = 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        if (lock_done) begin
          state_nxt = S_LOCKED;
          fc_clr    = 1'b1;
        end
      end
      default: state_nxt = S_LOCKED;
    endcase
  end

  always_comb begin
    status = ST_LOCKED;
    unique case (state)
      S_LOCKED:                 status = ST_LOCKED;
      S_UNLOCKED:               status = ST_UNLOCKED;
      S_ADJ_NEW, S_ADJ_CONFIRM: status = ST_ADJUST;
      S_LOCKOUT:                status = ST_LOCKOUT;
      default:                  status = ST_LOCKED;
    endcase
  end

  // the beep starts on the same edge that registers the event pulse
  beep_timer #(.BEEP_CYCLES(BEEP_CYCLES)) u_beep (
    .clk        (clk),
    .rst        (rst),
    .start      (succ_nxt | fail_nxt),
    .ok         (succ_nxt),
    .play       (play),
    .ok_not_fail(ok_not_fail)
  );

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: a cycle-level behavioural model queues
// expected per-cycle outputs and events; a negedge monitor pops and compares.
module tb_lock_sequencer;

  localparam int MAXF  = 3;
  localparam int LOCKC = 8;
  localparam int BEEPC = 4;

  localparam int M_LK  = 0;
  localparam int M_UN  = 1;
  localparam int M_NEW = 2;
  localparam int M_CF  = 3;
  localparam int M_LO  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pin_valid = 1'b0;
  logic [15:0] user_pin = '0;
  logic        btn_lock = 1'b0;
  logic [1:0]  sw = '0;
  logic [1:0]  status;
  logic [15:0] stored_pin;
  logic        success_event, fail_event, play, ok_not_fail;
  logic [1:0]  fail_count;

  lock_sequencer #(
    .MAX_FAILS     (MAXF),
    .LOCKOUT_CYCLES(LOCKC),
    .BEEP_CYCLES   (BEEPC),
    .DEFAULT_PIN   (16'h4321)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pin_valid    (pin_valid),
    .user_pin     (user_pin),
    .btn_lock     (btn_lock),
    .sw           (sw),
    .status       (status),
    .stored_pin   (stored_pin),
    .success_event(success_event),
    .fail_event   (fail_event),
    .play         (play),
    .ok_not_fail  (ok_not_fail),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  status;
    logic [15:0] pin;
    logic [1:0]  fc;
    bit          play;
    bit          ok;
  } exp_t;

  typedef struct {
    int cyc;
    bit succ;
  } ev_t;

  exp_t exp_q[$];
  ev_t  ev_q[$];

  int total = 0;
  int bad   = 0;

  int          m_mode;
  logic [15:0] m_pin, m_cand;
  int          m_fails, m_lock_end, m_beep_end;
  bit          m_ok, m_btn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] mode_status(input int mode);
    case (mode)
      M_LK:    return 2'd0;
      M_UN:    return 2'd1;
      M_LO:    return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  task automatic model_reset();
    m_mode     = M_LK;
    m_pin      = 16'h4321;
    m_cand     = '0;
    m_fails    = 0;
    m_lock_end = 0;
    m_beep_end = 0;
    m_ok       = 1'b0;
    m_btn      = 1'b0;
  endtask

  // one clock of stimulus; the model predicts what appears after the next edge
  task automatic step(input bit pv, input logic [15:0] pin, input bit btn, input bit sw1);
    int   e;
    bit   rise;
    int   ev;
    exp_t x;
    ev_t  q;
    @(negedge clk);
    #2;
    pin_valid = pv;
    user_pin  = pv ? pin : 16'($urandom);
    btn_lock  = btn;
    sw        = {sw1, 1'($urandom)};
    e    = cyc + 1;
    rise = btn && !m_btn;
    m_btn = btn;
    ev   = 0;
    case (m_mode)
      M_LK: if (pv) begin
        if (pin == m_pin) begin
          m_mode = M_UN; m_fails = 0; ev = 1;
        end else begin
          ev = 2;
          m_fails = (m_fails + 1 > 3) ? 3 : m_fails + 1;
          if (m_fails >= MAXF) begin
            m_mode = M_LO; m_lock_end = e + LOCKC;
          end
        end
      end
      M_LO: if (e == m_lock_end) begin
        m_mode = M_LK; m_fails = 0;
      end
      M_UN: begin
        if (rise) m_mode = M_LK;
        else if (sw1) m_mode = M_NEW;
      end
      M_NEW: begin
        if (rise) m_mode = M_LK;
        else if (!sw1) m_mode = M_UN;
        else if (pv) begin m_cand = pin; m_mode = M_CF; end
      end
      default: begin
        if (rise) m_mode = M_LK;
        else if (!sw1) m_mode = M_UN;
        else if (pv) begin
          if (pin == m_cand) begin m_pin = pin; ev = 1; end
          else ev = 2;
          m_mode = M_UN;
        end
      end
    endcase
    if (ev != 0) begin
      m_beep_end = e + BEEPC;
      m_ok       = (ev == 1);
      q.cyc = e; q.succ = (ev == 1);
      ev_q.push_back(q);
    end
    x.cyc    = e;
    x.status = mode_status(m_mode);
    x.pin    = m_pin;
    x.fc     = 2'(m_fails);
    x.play   = (e < m_beep_end);
    x.ok     = m_ok;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n, input bit sw1);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, sw1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; pin_valid = 1'b0; btn_lock = 1'b0; sw = '0;
    #1;
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_stored_pin", 32'(stored_pin), 32'h4321);
    chk("rst_play", 32'(play), 32'd0);
    chk("rst_ok_not_fail", 32'(ok_not_fail), 32'd0);
    chk("rst_fail_count", 32'(fail_count), 32'd0);
    chk("rst_events", 32'({success_event, fail_event}), 32'd0);
    exp_q.delete();
    ev_q.delete();
    model_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t x;
    ev_t  ev;
    if (!rst) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        x = exp_q.pop_front();
        chk("status", 32'(status), 32'(x.status));
        chk("stored_pin", 32'(stored_pin), 32'(x.pin));
        chk("fail_count", 32'(fail_count), 32'(x.fc));
        chk("play", 32'(play), 32'(x.play));
        if (x.play) chk("ok_not_fail", 32'(ok_not_fail), 32'(x.ok));
      end
      if (success_event || fail_event) begin
        if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
          ev = ev_q.pop_front();
          chk("ev_success", 32'(success_event), 32'(ev.succ));
          chk("ev_fail", 32'(fail_event), 32'(!ev.succ));
        end else begin
          chk("unexpected_event", 32'({success_event, fail_event}), 32'd0);
        end
      end
      while (ev_q.size() != 0 && ev_q[0].cyc <= cyc) begin
        ev = ev_q.pop_front();
        chk("missing_event", 32'({success_event, fail_event}), ev.succ ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    logic [15:0] p;
    bit          b, s;
    model_reset();
    do_reset();
    idle(2, 1'b0);

    // correct unlock and full beep
    step(1'b1, 16'h4321, 1'b0, 1'b0);
    idle(6, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    idle(1, 1'b0);

    // three wrong PINs into lockout, entry ignored during lockout
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h1111, 1'b0, 1'b0);
      idle(1, 1'b0);
    end
    step(1'b1, 16'h4321, 1'b0, 1'b0);
    idle(10, 1'b0);

    // PIN change, relock, old PIN fails, new PIN unlocks, reset mid-beep
    step(1'b1, 16'h4321, 1'b0, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 16'h9876, 1'b0, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 16'h9876, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 16'h4321, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 16'h9876, 1'b0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    idle(2, 1'b0);

    // adjust mismatch, then abort from confirm
    step(1'b1, 16'h4321, 1'b0, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 16'h9876, 1'b0, 1'b1);
    step(1'b1, 16'h9875, 1'b0, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 16'h9876, 1'b0, 1'b1);
    idle(1, 1'b1);
    idle(6, 1'b0);

    // lock edge together with pin_valid while unlocked
    step(1'b1, 16'h4321, 1'b1, 1'b0);
    idle(3, 1'b0);

    // randomized traffic
    b = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9, 0) == 0) b = ~b;
      if ($urandom_range(7, 0) == 0) s = ~s;
      r = int'($urandom_range(3, 0));
      p = (r == 1) ? m_cand : (r == 2) ? 16'($urandom) : m_pin;
      step($urandom_range(3, 0) == 0, p, b, s);
      if (i == 700) do_reset();
    end
    idle(3, 1'b0);
    @(negedge clk);
    #1;
    chk("leftover_events", 32'(ev_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_FAILS, default 3: consecutive wrong PINs that trigger lockout.
REQ-002 The block SHALL have parameter LOCKOUT_CYCLES, default 500_000_000: lockout duration in clk cycles.
REQ-003 The block SHALL have parameter BEEP_CYCLES, default 10_000_000: beep duration in clk cycles.
REQ-004 The block SHALL have parameter DEFAULT_PIN, default 16'h4321: stored PIN after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port pin_valid, input, 1 bit: one-cycle pulse marking a complete 4-digit entry, synchronous to clk.
REQ-008 The block SHALL have port user_pin, input, 16 bits: the entered PIN as 4 nibbles, valid when pin_valid is high.
REQ-009 The block SHALL have port btn_lock, input, 1 bit: debounced lock button, synchronous level.
REQ-010 The block SHALL have port sw, input, 2 bits: sw[1] requests adjust mode; sw[0] is reserved and ignored.
REQ-011 The block SHALL have port status, output, 2 bits: 0 locked, 1 unlocked, 2 adjust, 3 lockout.
REQ-012 The block SHALL have port stored_pin, output, 16 bits: the current PIN.
REQ-013 The block SHALL have ports success_event and fail_event, outputs, 1 bit each: one-cycle pulses.
REQ-014 The block SHALL have ports play and ok_not_fail, outputs, 1 bit each: tone-generator control.
REQ-015 The block SHALL have port fail_count, output, 2 bits: consecutive wrong-PIN count, saturating.

Function
REQ-016 The FSM SHALL have the states LOCKED, UNLOCKED, ADJ_NEW, ADJ_CONFIRM and LOCKOUT; status SHALL be 2 in both ADJ states.
REQ-017 In LOCKED, a pin_valid with user_pin equal to stored_pin SHALL go to UNLOCKED, pulse success_event and clear fail_count.
REQ-018 In LOCKED, a pin_valid with a mismatched PIN SHALL pulse fail_event and increment fail_count; when the count reaches MAX_FAILS the FSM SHALL go to LOCKOUT and load the lockout timer.
REQ-019 In LOCKOUT, pin_valid SHALL be ignored with no event; when the timer expires after LOCKOUT_CYCLES cycles the FSM SHALL go to LOCKED and clear fail_count.
REQ-020 btn_lock SHALL be edge-detected inside the block; only a rising edge acts.
REQ-021 In UNLOCKED, a rising edge of btn_lock SHALL go to LOCKED; otherwise sw[1]=1 SHALL go to ADJ_NEW; pin_valid SHALL be ignored.
REQ-022 In ADJ_NEW, pin_valid SHALL capture user_pin into a candidate register and go to ADJ_CONFIRM.
REQ-023 In ADJ_CONFIRM, a pin_valid equal to the candidate SHALL write stored_pin on the same edge, pulse success_event and go to UNLOCKED.
REQ-024 In ADJ_CONFIRM, a pin_valid not equal to the candidate SHALL pulse fail_event, leave stored_pin unchanged and go to UNLOCKED.
REQ-025 In either ADJ state, a btn_lock rising edge SHALL go to LOCKED and sw[1]=0 SHALL go to UNLOCKED; neither SHALL raise an event or change stored_pin.
REQ-026 Priority within a cycle SHALL be btn_lock edge, then sw[1] abort, then pin_valid.
REQ-027 Each success_event or fail_event SHALL, on the same edge, set play=1, load the beep counter with BEEP_CYCLES, and set ok_not_fail=1 for success or 0 for fail.
REQ-028 play SHALL fall exactly BEEP_CYCLES cycles after it was set.
REQ-029 A new event arriving while play=1 SHALL restart the beep counter and update ok_not_fail.
REQ-030 fail_count SHALL saturate at 3, and SHALL clear on a correct PIN or when lockout exits.
REQ-031 The timer widths SHALL be $clog2 of their parameter plus 1; counters SHALL never wrap.

Reset
REQ-032 Asserting rst SHALL immediately force state LOCKED, status 0, stored_pin=DEFAULT_PIN, candidate=0 and all counters 0.
REQ-033 Asserting rst SHALL immediately force success_event, fail_event, play and ok_not_fail to 0 and clear the btn_lock edge register.
REQ-034 Reset asserted mid-lockout, mid-adjust or mid-beep SHALL abandon the operation without emitting any event.

Structure
REQ-035 The shared package lock_pkg SHALL hold the state enum, the status encodings (ST_LOCKED, ST_UNLOCKED, ST_ADJUST, ST_LOCKOUT) and DEFAULT_PIN.
REQ-036 The beep sequencing SHALL be one sub-module, beep_timer, with inputs clk, rst, start, ok and outputs play, ok_not_fail.

Verification (bench parameters: MAX_FAILS=3, LOCKOUT_CYCLES=8, BEEP_CYCLES=4)
REQ-037 Correct unlock: from reset, pin_valid with 16'h4321 -> status=1 next cycle, one success_event, play=1 for exactly 4 cycles with ok_not_fail=1.
REQ-038 Lockout: three pin_valid with 16'h1111 -> three fail_event, fail_count 1,2,3, status=3 after the third; a pin_valid of 16'h4321 during lockout is ignored; status=0 after 8 cycles.
REQ-039 PIN change: unlock, sw[1]=1, enter 16'h9876 twice -> stored_pin=16'h9876, status=1; lock, then 16'h4321 fails and 16'h9876 unlocks.
REQ-040 Adjust mismatch or abort: candidate 16'h9876 then 16'h9875 -> fail_event, stored_pin stays 16'h4321; sw[1] dropped in ADJ_CONFIRM -> status=1 with no event.
REQ-041 Priority and reset: btn_lock edge coinciding with pin_valid in UNLOCKED -> LOCKED with no event; rst mid-beep -> play=0 at once and stored_pin=16'h4321.
